// File: rtl/button_conditioner.sv
// Five-key push-button conditioner: 2-flop sync, per-key debounce FSM, fixed-priority
// single-pulse outputs. Define BUTTON_AUTO_REPEAT_EN to enable auto-repeat on direction keys.
module button_conditioner #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_left,
  input  logic key_right,
  input  logic key_up,
  input  logic key_down,
  input  logic key_select,
  output logic button_left,
  output logic button_right,
  output logic button_up,
  output logic button_down,
  output logic button_select
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

  // Channel index: 0 left, 1 right, 2 up, 3 down, 4 select.
  localparam int NCH = 5;
  localparam int SEL = 4;

  logic [NCH-1:0] key_raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  state_e         state_q  [NCH];
  state_e         state_d  [NCH];
  logic [19:0]    db_cnt_q [NCH];
  logic [19:0]    db_cnt_d [NCH];
  logic [NCH-1:0] press;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] btn_d, btn_q;

  assign key_raw = {key_select, key_down, key_up, key_right, key_left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        db_cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the two synchronizer stages into one.
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      btn_q   <= btn_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d[i]  = state_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      press[i]    = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i]  = PRESS_DB;
            db_cnt_d[i] = '0;
          end
        end
        PRESS_DB: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (db_cnt_q[i] >= DEBOUNCE_CYCLES - 20'd1) begin
            state_d[i] = HELD;
            press[i]   = 1'b1;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 20'd1;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i]  = RELEASE_DB;
            db_cnt_d[i] = '0;
          end
        end
        RELEASE_DB: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (db_cnt_q[i] >= DEBOUNCE_CYCLES - 20'd1) begin
            state_d[i] = IDLE;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 20'd1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  // Repeat timers exist only for the four direction channels; select never repeats.
  logic [24:0]    rpt_cnt_q   [SEL];
  logic [24:0]    rpt_cnt_d   [SEL];
  logic [SEL-1:0] rpt_first_q, rpt_first_d;
  logic [NCH-1:0] rpt_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_first_q <= '0;
      for (int i = 0; i < SEL; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < SEL; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

  always_comb begin
    logic [24:0] lim;
    rpt_pulse   = '0;
    rpt_first_d = rpt_first_q;
    lim         = '0;
    for (int i = 0; i < SEL; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (state_d[i] == HELD && state_q[i] != HELD) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b1;
      end else if (state_q[i] == HELD && sync2_q[i]) begin
        lim = rpt_first_q[i] ? REPEAT_DELAY : {1'b0, REPEAT_PERIOD};
        if (rpt_cnt_q[i] >= lim - 25'd1) begin
          rpt_pulse[i]   = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_first_d[i] = 1'b0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 25'd1;
        end
      end
    end
  end

  assign pulse = press | rpt_pulse;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign pulse = press;
`endif

  // Fixed priority select > up > down > left > right; losers are dropped.
  always_comb begin
    btn_d = '0;
    if      (pulse[4]) btn_d[4] = 1'b1;
    else if (pulse[2]) btn_d[2] = 1'b1;
    else if (pulse[3]) btn_d[3] = 1'b1;
    else if (pulse[0]) btn_d[0] = 1'b1;
    else if (pulse[1]) btn_d[1] = 1'b1;
  end

  assign {button_select, button_down, button_up, button_right, button_left} = btn_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5).
// Reference model works on debounced run lengths of the 2-edge-delayed raw key levels.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 5;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_select = 1'b0;
  logic button_left, button_right, button_up, button_down, button_select;

  button_conditioner #(
    .DEBOUNCE_CYCLES(20'd4),
    .REPEAT_DELAY   (25'd10),
    .REPEAT_PERIOD  (24'd5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_select   (key_select),
    .button_left  (button_left),
    .button_right (button_right),
    .button_up    (button_up),
    .button_down  (button_down),
    .button_select(button_select)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state. Bit order of vectors: 0 left, 1 right, 2 up, 3 down, 4 select.
  logic [4:0] raw_d1, raw_d2;   // raw levels seen one and two edges ago
  bit         lvl   [5];        // debounced level
  int         run   [5];        // consecutive samples disagreeing with lvl
  int         tmr   [5];        // samples since hold start or last repeat
  bit         first [5];
  logic [4:0] exp_out;

  // Observation window bookkeeping.
  int edge_no;
  int pcount [5];
  int pedge  [5][8];

  function automatic logic [4:0] obs();
    return {button_select, button_down, button_up, button_right, button_left};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    raw_d1 = '0;
    raw_d2 = '0;
    exp_out = '0;
    for (int c = 0; c < 5; c++) begin
      lvl[c] = 1'b0; run[c] = 0; tmr[c] = 0; first[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [4:0] raw);
    logic [4:0] s, cand;
    int lim;
    s = raw_d2;
    raw_d2 = raw_d1;
    raw_d1 = raw;
    cand = '0;
    for (int c = 0; c < 5; c++) begin
      if (!lvl[c]) begin
        if (s[c]) begin
          run[c]++;
          if (run[c] == D + 1) begin
            lvl[c] = 1'b1; run[c] = 0; tmr[c] = 0; first[c] = 1'b1; cand[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end else if (!s[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          lvl[c] = 1'b0; run[c] = 0;
        end
      end else if (run[c] > 0) begin
        run[c] = 0; tmr[c] = 0; first[c] = 1'b1;
      end else if (REP_EN && c != 4) begin
        lim = first[c] ? R : P;
        if (tmr[c] == lim - 1) begin
          cand[c] = 1'b1; tmr[c] = 0; first[c] = 1'b0;
        end else begin
          tmr[c]++;
        end
      end
    end
    exp_out = '0;
    if      (cand[4]) exp_out[4] = 1'b1;
    else if (cand[2]) exp_out[2] = 1'b1;
    else if (cand[3]) exp_out[3] = 1'b1;
    else if (cand[0]) exp_out[0] = 1'b1;
    else if (cand[1]) exp_out[1] = 1'b1;
  endtask

  task automatic clear_window();
    edge_no = 0;
    for (int c = 0; c < 5; c++) pcount[c] = 0;
  endtask

  // Drive raw keys, take one edge, compare all outputs against the model.
  task automatic step(input logic [4:0] raw, input string tag);
    {key_select, key_down, key_up, key_right, key_left} = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    edge_no++;
    for (int c = 0; c < 5; c++) begin
      if (obs()[c]) begin
        if (pcount[c] < 8) pedge[c][pcount[c]] = edge_no;
        pcount[c]++;
      end
    end
    check(tag, {27'd0, obs()}, {27'd0, exp_out});
  endtask

  task automatic steps(input logic [4:0] raw, input int n, input string tag);
    for (int i = 0; i < n; i++) step(raw, tag);
  endtask

  // Asynchronous reset pulse lasting one clock edge, raised off-edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_out", {27'd0, obs()}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold_out", {27'd0, obs()}, 32'd0);
    rst_n = 1'b1;
  endtask

  int exp_n;
  int rel_exp [7] = '{0, 10, 15, 20, 25, 30, 35};
  int rem [5];
  logic [4:0] cur;

  initial begin
    model_reset();
    clear_window();
    #3;
    check("reset_state", {27'd0, obs()}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    steps(5'b00000, 5, "idle");

    // Clean press on up: one pulse at edge 7, nothing on release.
    clear_window();
    steps(5'b00100, 30, "clean_press");
    steps(5'b00000, 20, "clean_release");
    check("clean_up_count", pcount[2], (REP_EN ? 5 : 1));
    check("clean_up_latency", pedge[2][0], 7);

    // Bounce on left never qualifies.
    clear_window();
    steps(5'b00001, 2, "bounce");
    steps(5'b00000, 1, "bounce");
    steps(5'b00001, 2, "bounce");
    steps(5'b00000, 15, "bounce");
    check("bounce_left_count", pcount[0], 0);

    // Simultaneous select + right: select wins, right's press pulse is dropped.
    clear_window();
    steps(5'b10010, 30, "simul");
    steps(5'b00000, 20, "simul_release");
    check("simul_select_count", pcount[4], 1);
    check("simul_select_latency", pedge[4][0], 7);
    // Held right samples stay high for edges 3..32; repeats fall at 17, 22, 27, 32.
    check("simul_right_count", pcount[1], (REP_EN ? 4 : 0));

    // Reset during PRESS_DB with down held: full latency after deassert.
    clear_window();
    steps(5'b01000, 4, "mid_db");
    do_reset();
    clear_window();
    steps(5'b01000, 20, "after_reset");
    check("reset_down_count", pcount[3], 1);
    check("reset_down_latency", pedge[3][0], 7);
    steps(5'b00000, 20, "after_reset_release");

    // Right held 40 raw cycles: samples high through edge 42, so with repeat
    // the pulses land 0,10,15,20,25,30,35 cycles after the press.
    clear_window();
    steps(5'b00010, 40, "repeat_hold");
    steps(5'b00000, 20, "repeat_release");
    exp_n = REP_EN ? 7 : 1;
    check("repeat_right_count", pcount[1], exp_n);
    for (int k = 0; k < exp_n; k++)
      check($sformatf("repeat_right_rel%0d", k), pedge[1][k] - pedge[1][0] + 7, rel_exp[k] + 7);

    // Select held a long time yields exactly one pulse.
    clear_window();
    steps(5'b10000, 200, "select_long");
    steps(5'b00000, 20, "select_long_release");
    check("select_long_count", pcount[4], 1);

    // Randomized level runs on all keys with occasional resets.
    for (int c = 0; c < 5; c++) rem[c] = 0;
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 5; c++) begin
        if (rem[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          rem[c] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 40)));
        end
        rem[c]--;
      end
      step(cur, "random");
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
